// File: rtl/mem_rd_responder_if.sv
// mem_rd_responder_if: read-request bus between a read client (master) and mem_rd_responder (slave).
//   mem_req        client -> responder  level request, held until mem_gnt
//   mem_start_addr client -> responder  byte start address
//   mem_size_bytes client -> responder  number of bytes requested
//   mem_gnt        responder -> client  one-cycle response valid
//   mem_last       responder -> client  last beat, equal to mem_gnt
//   mem_data       responder -> client  response bytes, byte i at [8i+7:8i]
//   mem_last_valid responder -> client  index of last valid byte
//   size_err       responder -> client  request size was clamped
interface mem_rd_responder_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int WORD_WIDTH = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int MAX_BYTES_TO_RD = 20,
    parameter int LOG2_MAX_BYTES_TO_RD = $clog2(MAX_BYTES_TO_RD)
);
    logic                                    mem_req;
    logic [ADDR_WIDTH-1:0]                   mem_start_addr;
    logic [LOG2_MAX_BYTES_TO_RD-1:0]         mem_size_bytes;
    logic                                    mem_gnt;
    logic                                    mem_last;
    logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] mem_data;
    logic [$clog2(NUM_WORDS_IN_LINE)-1:0]    mem_last_valid;
    logic                                    size_err;
    modport master (
        output mem_req, mem_start_addr, mem_size_bytes,
        input  mem_gnt, mem_last, mem_data, mem_last_valid, size_err
    );
    modport slave (
        input  mem_req, mem_start_addr, mem_size_bytes,
        output mem_gnt, mem_last, mem_data, mem_last_valid, size_err
    );
endinterface

// File: rtl/mem_rd_responder.sv
// mem_rd_responder: serves a read request by fetching one or two SRAM lines and returning one byte-aligned beat.
//   clk, rst_n    clock and asynchronous active-low reset
//   mem           mem_rd_responder_if.slave request/response bus
//   sram_rd_en    SRAM read strobe
//   sram_rd_addr  SRAM line address
//   sram_rd_data  SRAM line data, valid one cycle after sram_rd_en
//   rsp_cnt       saturating count of grants      (only with MEM_RD_RSP_STATS_EN)
//   clamp_cnt     saturating count of size clamps (only with MEM_RD_RSP_STATS_EN)
module mem_rd_responder #(
    parameter int ADDR_WIDTH = 19,
    parameter int WORD_WIDTH = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int MAX_BYTES_TO_RD = 20,
    parameter int LOG2_MAX_BYTES_TO_RD = $clog2(MAX_BYTES_TO_RD),
    parameter int LINE_AW = ADDR_WIDTH - $clog2(NUM_WORDS_IN_LINE)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    mem_rd_responder_if.slave                       mem,
    output logic                                    sram_rd_en,
    output logic [LINE_AW-1:0]                      sram_rd_addr,
    input  logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] sram_rd_data
`ifdef MEM_RD_RSP_STATS_EN
    ,
    output logic [15:0]                             rsp_cnt,
    output logic [7:0]                              clamp_cnt
`endif
);
    localparam int OFF_W = $clog2(NUM_WORDS_IN_LINE);
    localparam int LW = NUM_WORDS_IN_LINE * WORD_WIDTH;
    typedef enum logic [2:0] {IDLE, RD0, RD1, WAIT, RESP} state_t;
    state_t                          state;
    logic [OFF_W-1:0]                off;
    logic [LINE_AW-1:0]              line0;
    logic [LOG2_MAX_BYTES_TO_RD-1:0] size;
    logic                            err;
    logic                            span;
    logic [LW-1:0]                   lo;
    logic [OFF_W-1:0]                req_off;
    logic [LOG2_MAX_BYTES_TO_RD-1:0] req_size;
    logic                            req_clamp;
    logic [2*LW-1:0]                 pair;
    logic [LW-1:0]                   data_next;
    always_comb begin
        req_off   = mem.mem_start_addr[OFF_W-1:0];
        req_clamp = 32'(mem.mem_size_bytes) > MAX_BYTES_TO_RD;
        req_size  = req_clamp ? LOG2_MAX_BYTES_TO_RD'(MAX_BYTES_TO_RD) : mem.mem_size_bytes;
        // Non-spanning responses never index past the low line, so the upper half is a don't-care there.
        pair      = {sram_rd_data, span ? lo : sram_rd_data};
        for (int i = 0; i < NUM_WORDS_IN_LINE; i++)
            data_next[i*WORD_WIDTH +: WORD_WIDTH] = (i < 32'(size)) ?
                pair[(32'(off) + i)*WORD_WIDTH +: WORD_WIDTH] : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            off                <= '0;
            line0              <= '0;
            size               <= '0;
            err                <= 1'b0;
            span               <= 1'b0;
            lo                 <= '0;
            sram_rd_en         <= 1'b0;
            sram_rd_addr       <= '0;
            mem.mem_gnt        <= 1'b0;
            mem.mem_last       <= 1'b0;
            mem.size_err       <= 1'b0;
            mem.mem_data       <= '0;
            mem.mem_last_valid <= '0;
        end else begin
            case (state)
                IDLE: if (mem.mem_req) begin
                    state        <= RD0;
                    off          <= req_off;
                    line0        <= mem.mem_start_addr[ADDR_WIDTH-1:OFF_W];
                    size         <= req_size;
                    err          <= req_clamp;
                    span         <= 32'(req_off) + 32'(req_size) > NUM_WORDS_IN_LINE;
                    sram_rd_en   <= 1'b1;
                    sram_rd_addr <= mem.mem_start_addr[ADDR_WIDTH-1:OFF_W];
                end
                RD0: begin
                    state        <= span ? RD1 : WAIT;
                    sram_rd_en   <= span;
                    sram_rd_addr <= span ? line0 + 1'b1 : line0;
                end
                RD1: begin
                    state      <= WAIT;
                    sram_rd_en <= 1'b0;
                    lo         <= sram_rd_data;
                end
                WAIT: begin
                    state              <= RESP;
                    mem.mem_gnt        <= 1'b1;
                    mem.mem_last       <= 1'b1;
                    mem.size_err       <= err;
                    mem.mem_data       <= data_next;
                    mem.mem_last_valid <= (size == '0) ? '0 : OFF_W'(size - 1'b1);
                end
                RESP: begin
                    state        <= IDLE;
                    mem.mem_gnt  <= 1'b0;
                    mem.mem_last <= 1'b0;
                    mem.size_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MEM_RD_RSP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_cnt   <= '0;
            clamp_cnt <= '0;
        end else begin
            if (mem.mem_gnt && rsp_cnt != '1) rsp_cnt <= rsp_cnt + 1'b1;
            if (mem.size_err && clamp_cnt != '1) clamp_cnt <= clamp_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_rd_responder.sv
// tb_mem_rd_responder: directed vector bench for mem_rd_responder with a one-cycle-latency SRAM model.
module tb_mem_rd_responder;
    typedef struct {
        logic [18:0]  addr;
        logic [4:0]   size;
        logic [13:0]  line;
        logic         span;
        logic         err;
        logic [4:0]   lv;
        logic [255:0] data;
    } vec_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sram_rd_en;
    logic [13:0]  sram_rd_addr;
    logic [255:0] sram_rd_data = '0;
`ifdef MEM_RD_RSP_STATS_EN
    logic [15:0]  rsp_cnt;
    logic [7:0]   clamp_cnt;
`endif
    int nchk = 0;
    int npass = 0;
    vec_t vecs[10];
    mem_rd_responder_if mem_if();
    mem_rd_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem(mem_if),
        .sram_rd_en(sram_rd_en),
        .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data)
`ifdef MEM_RD_RSP_STATS_EN
        ,
        .rsp_cnt(rsp_cnt),
        .clamp_cnt(clamp_cnt)
`endif
    );
    always #5 clk = ~clk;
    // Line contents: line 4 -> 80+k, top line -> E0+k, line 2 -> 40+k, every other line -> k.
    function automatic logic [255:0] line_pat(input logic [13:0] l);
        logic [255:0] r;
        logic [7:0] base;
        base = (l == 14'd4) ? 8'h80 : (l == 14'h3FFF) ? 8'hE0 : (l == 14'd2) ? 8'h40 : 8'h00;
        for (int k = 0; k < 32; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction
    always @(posedge clk) if (sram_rd_en) sram_rd_data <= line_pat(sram_rd_addr);
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic wait_gnt(input bit drop, output int lat, output int nrd,
                            output logic [13:0] a0, output logic [13:0] a1);
        lat = -1;
        nrd = 0;
        a0 = '0;
        a1 = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (drop) mem_if.mem_req = 1'b0;
            if (sram_rd_en) begin
                if (nrd == 0) a0 = sram_rd_addr;
                else a1 = sram_rd_addr;
                nrd++;
            end
            if (mem_if.mem_gnt) begin
                lat = k + 1;
                break;
            end
        end
    endtask
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int nrd;
        logic [13:0] a0;
        logic [13:0] a1;
        logic [13:0] nl;
        @(posedge clk);
        @(negedge clk);
        mem_if.mem_req = 1'b1;
        mem_if.mem_start_addr = v.addr;
        mem_if.mem_size_bytes = v.size;
        wait_gnt(1'b1, lat, nrd, a0, a1);
        nl = v.line + 14'd1;
        chk($sformatf("v%0d latency", idx), lat, v.span ? 4 : 3);
        chk($sformatf("v%0d reads", idx), nrd, v.span ? 2 : 1);
        chk($sformatf("v%0d rd_addr0", idx), a0, v.line);
        if (v.span) chk($sformatf("v%0d rd_addr1", idx), a1, nl);
        chk($sformatf("v%0d data", idx), mem_if.mem_data, v.data);
        chk($sformatf("v%0d last_valid", idx), mem_if.mem_last_valid, v.lv);
        chk($sformatf("v%0d last", idx), mem_if.mem_last, 1);
        chk($sformatf("v%0d size_err", idx), mem_if.size_err, v.err);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d gnt pulse", idx), mem_if.mem_gnt, 0);
    endtask
    initial begin
        int lat;
        int nrd;
        int ng;
        int g1;
        int g2;
        logic [13:0] a0;
        logic [13:0] a1;
        logic gseen;
        vecs[0] = '{19'd0,       5'd4,  14'd0,      1'b0, 1'b0, 5'd3,  256'h03020100};
        vecs[1] = '{19'd126,     5'd4,  14'd3,      1'b1, 1'b0, 5'd3,  256'h81801F1E};
        vecs[2] = '{19'h00040,   5'd25, 14'd2,      1'b0, 1'b1, 5'd19, 256'h53525150_4F4E4D4C_4B4A4948_47464544_43424140};
        vecs[3] = '{19'h7FFFE,   5'd4,  14'h3FFF,   1'b1, 1'b0, 5'd3,  256'h0100FFFE};
        vecs[4] = '{19'd5,       5'd0,  14'd0,      1'b0, 1'b0, 5'd0,  256'h0};
        vecs[5] = '{19'd10,      5'd20, 14'd0,      1'b0, 1'b0, 5'd19, 256'h1D1C1B1A_19181716_15141312_11100F0E_0D0C0B0A};
        vecs[6] = '{19'd116,     5'd20, 14'd3,      1'b1, 1'b0, 5'd19, 256'h87868584_83828180_1F1E1D1C_1B1A1918_17161514};
        vecs[7] = '{19'd28,      5'd4,  14'd0,      1'b0, 1'b0, 5'd3,  256'h1F1E1D1C};
        vecs[8] = '{19'd0,       5'd31, 14'd0,      1'b0, 1'b1, 5'd19, 256'h13121110_0F0E0D0C_0B0A0908_07060504_03020100};
        vecs[9] = '{19'd63,      5'd1,  14'd1,      1'b0, 1'b0, 5'd0,  256'h1F};
        mem_if.mem_req = 1'b0;
        mem_if.mem_start_addr = '0;
        mem_if.mem_size_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset gnt", mem_if.mem_gnt, 0);
        chk("reset last", mem_if.mem_last, 0);
        chk("reset size_err", mem_if.size_err, 0);
        chk("reset rd_en", sram_rd_en, 0);
        chk("reset rd_addr", sram_rd_addr, 0);
        chk("reset data", mem_if.mem_data, 0);
        chk("reset last_valid", mem_if.mem_last_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
`ifdef MEM_RD_RSP_STATS_EN
        chk("rsp_cnt after vectors", rsp_cnt, 10);
        chk("clamp_cnt after vectors", clamp_cnt, 2);
`endif
        @(posedge clk);
        @(negedge clk);
        mem_if.mem_req = 1'b1;
        mem_if.mem_start_addr = 19'd126;
        mem_if.mem_size_bytes = 5'd4;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rd1 strobe before reset", sram_rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset rd_en", sram_rd_en, 0);
        chk("async reset gnt", mem_if.mem_gnt, 0);
        gseen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (mem_if.mem_gnt || sram_rd_en) gseen = 1'b1;
        end
        chk("quiet during reset", gseen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(1'b0, lat, nrd, a0, a1);
        mem_if.mem_req = 1'b0;
        chk("post-reset latency", lat, 4);
        chk("post-reset reads", nrd, 2);
        chk("post-reset rd_addr0", a0, 3);
        chk("post-reset rd_addr1", a1, 4);
        chk("post-reset data", mem_if.mem_data, 256'h81801F1E);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_if.mem_req = 1'b1;
        mem_if.mem_start_addr = 19'd0;
        mem_if.mem_size_bytes = 5'd4;
        ng = 0;
        g1 = -1;
        g2 = -1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (mem_if.mem_gnt) begin
                ng++;
                if (ng == 1) begin
                    g1 = k;
                    chk("b2b first data", mem_if.mem_data, 256'h03020100);
                    mem_if.mem_start_addr = 19'd128;
                end else if (ng == 2) begin
                    g2 = k;
                    chk("b2b second data", mem_if.mem_data, 256'h83828180);
                    mem_if.mem_req = 1'b0;
                end
            end
        end
        chk("b2b grant count", ng, 2);
        chk("b2b grant spacing", g2 - g1, 4);
`ifdef MEM_RD_RSP_STATS_EN
        chk("b2b rsp_cnt", rsp_cnt, 2);
        chk("b2b clamp_cnt", clamp_cnt, 0);
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/mem_rd_responder.md
Name: mem_rd_responder

Overview:
Memory-side responder for the accelerator read-request interface. It serves mem_req / mem_start_addr / mem_size_bytes requests from a read client such as the CNN picture or weight port. It fetches one or two 32-byte SRAM lines, byte-aligns them and returns a single-beat response with mem_gnt, mem_last and mem_last_valid. One instance sits between each read client and its SRAM bank.

Parameters:
ADDR_WIDTH, 19, byte address width of mem_start_addr.
WORD_WIDTH, 8, bits per word (byte).
NUM_WORDS_IN_LINE, 32, words per SRAM line and per response beat.
MAX_BYTES_TO_RD, 20, largest legal request size in bytes.
LOG2_MAX_BYTES_TO_RD, $clog2(MAX_BYTES_TO_RD), width of mem_size_bytes.
LINE_AW, ADDR_WIDTH-$clog2(NUM_WORDS_IN_LINE), SRAM line address width.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- mem_req  in  1  client read request; level, held until mem_gnt.
- mem_start_addr  in  ADDR_WIDTH  byte start address.
- mem_size_bytes  in  LOG2_MAX_BYTES_TO_RD  bytes requested.
- mem_gnt  out  1  response valid, one-cycle pulse.
- mem_last  out  1  last beat; always equal to mem_gnt (single-beat protocol).
- mem_data  out  NUM_WORDS_IN_LINE*WORD_WIDTH  response bytes; byte i is at bits [8i+7:8i].
- mem_last_valid  out  $clog2(NUM_WORDS_IN_LINE)  index of last valid byte.
- size_err  out  1  pulses with mem_gnt when the request was clamped.
- sram_rd_en  out  1  SRAM read strobe.
- sram_rd_addr  out  LINE_AW  SRAM line address.
- sram_rd_data  in  NUM_WORDS_IN_LINE*WORD_WIDTH  SRAM data, valid 1 cycle after sram_rd_en.

Behaviour:
- Reset: state=IDLE; mem_gnt, mem_last, size_err and sram_rd_en are 0; mem_data, mem_last_valid and sram_rd_addr are 0. Any in-flight request is dropped, and the client must re-request.
- FSM states: IDLE, RD0, RD1, WAIT, RESP.
- IDLE: when mem_req=1, register the request and go to RD0.
  - Registered fields: off=addr[4:0], line0=addr[ADDR_WIDTH-1:5], size.
  - If size>MAX_BYTES_TO_RD, clamp size to MAX_BYTES_TO_RD and set the err flag.
  - span = (off+size > NUM_WORDS_IN_LINE).
- RD0: sram_rd_en=1, sram_rd_addr=line0. Go to RD1 if span, else WAIT.
- RD1: sram_rd_en=1, sram_rd_addr=line0+1, wrapping modulo 2^LINE_AW. Capture line0 data into lo. Go to WAIT.
- WAIT: capture the returning data, into hi if span, else into lo. Go to RESP.
- RESP: mem_gnt=1, mem_last=1, size_err=err.
  - mem_data byte i = ({hi,lo} >> 8*off) byte i for i<size; 0 for i>=size.
  - mem_last_valid = size-1.
  - Go to IDLE.
- Outputs are registered: they come from state and data registers, with no combinational path from mem_req to any output.
- Latency, counting the cycle IDLE samples mem_req as c0:
  - non-spanning request: mem_gnt high in c3;
  - spanning request: mem_gnt high in c4.
- Requests are accepted only in IDLE. mem_req is ignored in every other state, including the RESP cycle. The earliest next accept is the cycle after mem_gnt, so back-to-back requests have 4 or 5 cycles between grants.
- If mem_req drops mid-transaction, the transaction still completes and mem_gnt is still issued.
- Size 0: no span, mem_data all zero, mem_last_valid=0, mem_gnt issued normally.
- mem_data, mem_last_valid and size_err are valid only while mem_gnt=1. Outside mem_gnt, mem_data holds its last value.

Optional Feature:
MEM_RD_RSP_STATS_EN
- Defined: adds output rsp_cnt (16 bits), reset to 0, incremented on every mem_gnt and saturating at 16'hFFFF. Also adds output clamp_cnt (8 bits), incremented on every size_err and saturating.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Aligned request, SRAM line0 byte k = k: addr=0, size=4 -> mem_gnt in c3, bytes 0..3 = 00,01,02,03, bytes 4..31 = 0, mem_last_valid=3, mem_last=1, exactly one sram_rd_en.
- Spanning request, line3 byte k = k, line4 byte k = 8'h80+k: addr=3*32+30=126, size=4 -> two reads (line addresses 3 then 4), mem_gnt in c4, bytes = 1E,1F,80,81, mem_last_valid=3.
- Clamp: size=25, addr=0x40 -> 20 bytes returned, mem_last_valid=19, size_err=1 with mem_gnt; bytes 20..31 = 0.
- Wrap: addr=2^19-2, size=4 -> sram_rd_addr=0x3FFF then 0x0000, data = last 2 bytes of the top line followed by first 2 bytes of line 0.
- Reset mid-operation: assert rst_n=0 while in RD1 -> mem_gnt never pulses, sram_rd_en=0 immediately. After release with mem_req still 1, a fresh transaction completes with correct data.
- Back-to-back: mem_req held high across two requests (addr 0 then 128, size 4) -> exactly two mem_gnt pulses, 4 cycles apart. With MEM_RD_RSP_STATS_EN defined, rsp_cnt=2.
